// File: rtl/demux_deser4.sv
// Purpose: routes a strobed serial bit stream to one of four channels and assembles W-bit words per channel.
// Latency: a word is presented on q_c/v_c the cycle after the edge that samples its last bit.
// Backpressure: v_c holds until ack_c; a word completing while v_c is held and unacked is dropped and sets ovf_c.
module demux_deser4 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         D,
    input  logic         s0,
    input  logic         s1,
    input  logic         en,
    input  logic         ack0,
    input  logic         ack1,
    input  logic         ack2,
    input  logic         ack3,
    output logic [W-1:0] q0,
    output logic [W-1:0] q1,
    output logic [W-1:0] q2,
    output logic [W-1:0] q3,
    output logic         v0,
    output logic         v1,
    output logic         v2,
    output logic         v3,
    output logic         ovf0,
    output logic         ovf1,
    output logic         ovf2,
    output logic         ovf3
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    // Per-channel state
    logic [W-1:0]  sr_r  [4];
    logic [CW-1:0] cnt_r [4];
    logic [W-1:0]  q_r   [4];
    logic [3:0]    v_r;
    logic [3:0]    ovf_r;

    // Per-channel decoded control
    logic [1:0]    sel;
    logic [3:0]    ack;
    logic [3:0]    hit;
    logic [3:0]    complete;
    logic [3:0]    load;
    logic [3:0]    drop;
    logic [W-1:0]  word  [4];

    assign sel = {s1, s0};
    assign ack = {ack3, ack2, ack1, ack0};

    // Decode which channel takes this bit and whether that bit finishes a word it can deliver.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            hit[c]      = 1'b0;
            complete[c] = 1'b0;
            load[c]     = 1'b0;
            drop[c]     = 1'b0;
            word[c]     = {sr_r[c][W-2:0], D};
            hit[c]      = en && (sel == 2'(c));
            complete[c] = hit[c] && (cnt_r[c] == LAST);
            // A held word can be replaced only if the consumer takes it this same cycle.
            load[c]     = complete[c] && (!v_r[c] || ack[c]);
            drop[c]     = complete[c] && v_r[c] && !ack[c];
        end
    end

    // Shift/count on strobe, publish finished words, retire acked words, latch overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                sr_r[c]  <= '0;
                cnt_r[c] <= '0;
                q_r[c]   <= '0;
            end
            v_r   <= '0;
            ovf_r <= '0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (hit[c]) begin
                    sr_r[c]  <= word[c];
                    cnt_r[c] <= complete[c] ? '0 : cnt_r[c] + CW'(1);
                end
                if (load[c]) begin
                    q_r[c] <= word[c];
                    v_r[c] <= 1'b1;
                end else if (v_r[c] && ack[c]) begin
                    v_r[c] <= 1'b0;
                end
                if (drop[c]) begin
                    ovf_r[c] <= 1'b1;
                end
            end
        end
    end

    assign q0   = q_r[0];
    assign q1   = q_r[1];
    assign q2   = q_r[2];
    assign q3   = q_r[3];
    assign v0   = v_r[0];
    assign v1   = v_r[1];
    assign v2   = v_r[2];
    assign v3   = v_r[3];
    assign ovf0 = ovf_r[0];
    assign ovf1 = ovf_r[1];
    assign ovf2 = ovf_r[2];
    assign ovf3 = ovf_r[3];

endmodule

// File: tb/tb_demux_deser4.sv
// Purpose: directed, table-driven check of demux_deser4 at W=4.
// Latency: every vector is compared one edge after it is applied.
// Backpressure: exercised through ack/overflow vectors.
module tb_demux_deser4;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         D;
    logic         s0;
    logic         s1;
    logic         en;
    logic         ack0, ack1, ack2, ack3;
    logic [W-1:0] q0, q1, q2, q3;
    logic         v0, v1, v2, v3;
    logic         ovf0, ovf1, ovf2, ovf3;

    int checks;
    int errors;

    demux_deser4 #(.W(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .D    (D),
        .s0   (s0),
        .s1   (s1),
        .en   (en),
        .ack0 (ack0),
        .ack1 (ack1),
        .ack2 (ack2),
        .ack3 (ack3),
        .q0   (q0),
        .q1   (q1),
        .q2   (q2),
        .q3   (q3),
        .v0   (v0),
        .v1   (v1),
        .v2   (v2),
        .v3   (v3),
        .ovf0 (ovf0),
        .ovf1 (ovf1),
        .ovf2 (ovf2),
        .ovf3 (ovf3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic [1:0]  sel;
        logic        d;
        logic [3:0]  ack;
        logic [3:0]  ev;
        logic [3:0]  eovf;
        logic [15:0] eq;   // {q3,q2,q1,q0}
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic e, logic [1:0] s, logic d, logic [3:0] a,
                                logic [3:0] ev, logic [3:0] eo, logic [15:0] eq);
        vec_t t;
        t.rst = r; t.en = e; t.sel = s; t.d = d; t.ack = a;
        t.ev = ev; t.eovf = eo; t.eq = eq;
        return t;
    endfunction

    task automatic drive(logic r, logic e, logic [1:0] s, logic d, logic [3:0] a);
        rst = r; en = e; s1 = s[1]; s0 = s[0]; D = d;
        {ack3, ack2, ack1, ack0} = a;
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; en = 1'b0; D = 1'b0; s0 = 1'b0; s1 = 1'b0;
        {ack3, ack2, ack1, ack0} = 4'b0000;

        //                 rst  en  sel    d     ack      ev       ovf      {q3,q2,q1,q0}
        // Reset with strobe toggling
        vecs.push_back(mk(1'b1,1'b1,2'd0,1'b1,4'b0000,4'b0000,4'b0000,16'h0000));
        vecs.push_back(mk(1'b1,1'b0,2'd0,1'b0,4'b0000,4'b0000,4'b0000,16'h0000));
        // Single word on ch0: 1,0,1,1
        vecs.push_back(mk(1'b0,1'b1,2'd0,1'b1,4'b0000,4'b0000,4'b0000,16'h0000));
        vecs.push_back(mk(1'b0,1'b1,2'd0,1'b0,4'b0000,4'b0000,4'b0000,16'h0000));
        vecs.push_back(mk(1'b0,1'b1,2'd0,1'b1,4'b0000,4'b0000,4'b0000,16'h0000));
        vecs.push_back(mk(1'b0,1'b1,2'd0,1'b1,4'b0000,4'b0001,4'b0000,16'h000B));
        vecs.push_back(mk(1'b0,1'b0,2'd0,1'b0,4'b0001,4'b0000,4'b0000,16'h000B));
        // Interleave ch2 (1,1,0,0) and ch3 (0,1,0,1)
        vecs.push_back(mk(1'b0,1'b1,2'd2,1'b1,4'b0000,4'b0000,4'b0000,16'h000B));
        vecs.push_back(mk(1'b0,1'b1,2'd3,1'b0,4'b0000,4'b0000,4'b0000,16'h000B));
        vecs.push_back(mk(1'b0,1'b1,2'd2,1'b1,4'b0000,4'b0000,4'b0000,16'h000B));
        vecs.push_back(mk(1'b0,1'b1,2'd3,1'b1,4'b0000,4'b0000,4'b0000,16'h000B));
        vecs.push_back(mk(1'b0,1'b1,2'd2,1'b0,4'b0000,4'b0000,4'b0000,16'h000B));
        vecs.push_back(mk(1'b0,1'b1,2'd3,1'b0,4'b0000,4'b0000,4'b0000,16'h000B));
        vecs.push_back(mk(1'b0,1'b1,2'd2,1'b0,4'b0000,4'b0100,4'b0000,16'h0C0B));
        vecs.push_back(mk(1'b0,1'b1,2'd3,1'b1,4'b0000,4'b1100,4'b0000,16'h5C0B));
        vecs.push_back(mk(1'b0,1'b0,2'd0,1'b0,4'b1100,4'b0000,4'b0000,16'h5C0B));
        // Overflow on ch1: 1111 then 0000 without ack
        vecs.push_back(mk(1'b0,1'b1,2'd1,1'b1,4'b0000,4'b0000,4'b0000,16'h5C0B));
        vecs.push_back(mk(1'b0,1'b1,2'd1,1'b1,4'b0000,4'b0000,4'b0000,16'h5C0B));
        vecs.push_back(mk(1'b0,1'b1,2'd1,1'b1,4'b0000,4'b0000,4'b0000,16'h5C0B));
        vecs.push_back(mk(1'b0,1'b1,2'd1,1'b1,4'b0000,4'b0010,4'b0000,16'h5CFB));
        vecs.push_back(mk(1'b0,1'b1,2'd1,1'b0,4'b0000,4'b0010,4'b0000,16'h5CFB));
        vecs.push_back(mk(1'b0,1'b1,2'd1,1'b0,4'b0000,4'b0010,4'b0000,16'h5CFB));
        vecs.push_back(mk(1'b0,1'b1,2'd1,1'b0,4'b0000,4'b0010,4'b0000,16'h5CFB));
        vecs.push_back(mk(1'b0,1'b1,2'd1,1'b0,4'b0000,4'b0010,4'b0010,16'h5CFB));
        vecs.push_back(mk(1'b0,1'b0,2'd0,1'b0,4'b0010,4'b0000,4'b0010,16'h5CFB));
        // ch1 word 0011, then 1010 completing with ack1 in the same cycle
        vecs.push_back(mk(1'b0,1'b1,2'd1,1'b0,4'b0000,4'b0000,4'b0010,16'h5CFB));
        vecs.push_back(mk(1'b0,1'b1,2'd1,1'b0,4'b0000,4'b0000,4'b0010,16'h5CFB));
        vecs.push_back(mk(1'b0,1'b1,2'd1,1'b1,4'b0000,4'b0000,4'b0010,16'h5CFB));
        vecs.push_back(mk(1'b0,1'b1,2'd1,1'b1,4'b0000,4'b0010,4'b0010,16'h5C3B));
        vecs.push_back(mk(1'b0,1'b1,2'd1,1'b1,4'b0000,4'b0010,4'b0010,16'h5C3B));
        vecs.push_back(mk(1'b0,1'b1,2'd1,1'b0,4'b0000,4'b0010,4'b0010,16'h5C3B));
        vecs.push_back(mk(1'b0,1'b1,2'd1,1'b1,4'b0000,4'b0010,4'b0010,16'h5C3B));
        vecs.push_back(mk(1'b0,1'b1,2'd1,1'b0,4'b0010,4'b0010,4'b0010,16'h5CAB));
        vecs.push_back(mk(1'b0,1'b0,2'd0,1'b0,4'b0010,4'b0000,4'b0010,16'h5CAB));
        // Reset mid-word on ch0, with strobe and acks asserted alongside reset
        vecs.push_back(mk(1'b0,1'b1,2'd0,1'b1,4'b0000,4'b0000,4'b0010,16'h5CAB));
        vecs.push_back(mk(1'b0,1'b1,2'd0,1'b1,4'b0000,4'b0000,4'b0010,16'h5CAB));
        vecs.push_back(mk(1'b1,1'b1,2'd0,1'b1,4'b1111,4'b0000,4'b0000,16'h0000));
        vecs.push_back(mk(1'b0,1'b1,2'd0,1'b0,4'b0000,4'b0000,4'b0000,16'h0000));
        vecs.push_back(mk(1'b0,1'b1,2'd0,1'b1,4'b0000,4'b0000,4'b0000,16'h0000));
        vecs.push_back(mk(1'b0,1'b1,2'd0,1'b1,4'b0000,4'b0000,4'b0000,16'h0000));
        vecs.push_back(mk(1'b0,1'b1,2'd0,1'b0,4'b0000,4'b0001,4'b0000,16'h0006));
        // Acks on idle channels are ignored
        vecs.push_back(mk(1'b0,1'b0,2'd0,1'b0,4'b1110,4'b0001,4'b0000,16'h0006));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].sel, vecs[i].d, vecs[i].ack);
            check($sformatf("vec%0d_v", i),   32'({v3, v2, v1, v0}),         32'(vecs[i].ev));
            check($sformatf("vec%0d_ovf", i), 32'({ovf3, ovf2, ovf1, ovf0}), 32'(vecs[i].eovf));
            check($sformatf("vec%0d_q", i),   32'({q3, q2, q1, q0}),         32'(vecs[i].eq));
        end

        // ch3 word 1001 with ack3 held high the whole time: ignored while idle,
        // lets the word load, then retires it on the following cycle.
        drive(1'b0, 1'b1, 2'd3, 1'b1, 4'b1000);
        check("ack_idle_v3", 32'(v3), 32'd0);
        drive(1'b0, 1'b1, 2'd3, 1'b0, 4'b1000);
        drive(1'b0, 1'b1, 2'd3, 1'b0, 4'b1000);
        drive(1'b0, 1'b1, 2'd3, 1'b1, 4'b1000);
        check("held_ack_load_v3", 32'(v3), 32'd1);
        check("held_ack_load_q3", 32'(q3), 32'h9);
        check("held_ack_ovf3", 32'(ovf3), 32'd0);
        drive(1'b0, 1'b0, 2'd0, 1'b0, 4'b1000);
        check("held_ack_clear_v3", 32'(v3), 32'd0);
        check("held_ack_keep_q3", 32'(q3), 32'h9);
        check("other_ch_v0_held", 32'(v0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
